// File: rtl/cdb_arbiter_pkg.sv
// Shared pipeline types for the common data bus (CDB) arbiter:
// FU result bundle, CDB broadcast packet and default sizing.
package cdb_arbiter_pkg;

   localparam int DEF_NUM_FU    = 8;
   localparam int DEF_CDB_WIDTH = 2;

   localparam int XLEN  = 32;
   localparam int PRF_W = 6;
   localparam int ROB_W = 5;

   typedef struct packed {
      logic             valid;
      logic [XLEN-1:0]  value;
      logic             value_valid;
      logic [PRF_W-1:0] dest_prf;
      logic [ROB_W-1:0] rob_entry;
      logic [XLEN-1:0]  branch_address;
   } FUNC_OUTPUT;

   typedef struct packed {
      logic             valid;
      logic [XLEN-1:0]  value;
      logic             value_valid;
      logic [PRF_W-1:0] dest_prf;
      logic [ROB_W-1:0] rob_entry;
      logic [XLEN-1:0]  branch_address;
   } CDB_PACKET;

   // Both bundles share one layout, so a cast copies every field.
   function automatic CDB_PACKET fu_to_cdb(input FUNC_OUTPUT f);
      CDB_PACKET p;
      p       = CDB_PACKET'(f);
      p.valid = 1'b1;
      return p;
   endfunction

endpackage

// File: rtl/cdb_arbiter_pick.sv
// rr_pick_n: combinational circular priority picker.
// req_i: requests, ptr_i: start index; gnt_o: one-hot grants,
// slot_vld_o/slot_idx_o: up to K grants in search order.
module rr_pick_n
   import cdb_arbiter_pkg::*;
#(
   parameter int N  = DEF_NUM_FU,
   parameter int K  = DEF_CDB_WIDTH,
   parameter int IW = (N > 1) ? $clog2(N) : 1
)(
   input  logic [N-1:0]         req_i,
   input  logic [IW-1:0]        ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [K-1:0]         slot_vld_o,
   output logic [K-1:0][IW-1:0] slot_idx_o
);

   always_comb begin
      int            n;
      int            k;
      logic [IW-1:0] idx;
      gnt_o      = '0;
      slot_vld_o = '0;
      slot_idx_o = '0;
      n          = 0;
      k          = 0;
      idx        = '0;
      for (int j = 0; j < N; j++) begin
         k = int'(ptr_i) + j;
         if (k >= N) k = k - N;
         idx = IW'(k);
         if (req_i[idx] && (n < K)) begin
            gnt_o[idx] = 1'b1;
            for (int s = 0; s < K; s++) begin
               if (s == n) begin
                  slot_vld_o[s] = 1'b1;
                  slot_idx_o[s] = idx;
               end
            end
            n = n + 1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants up to CDB_WIDTH FU results per cycle, round robin.
// Ports: clock, reset (async low), fu_out, squash; fu_sel, cdb, rr_ptr.
module cdb_arbiter
   import cdb_arbiter_pkg::*;
#(
   parameter int  NUM_FU    = DEF_NUM_FU,
   parameter int  CDB_WIDTH = DEF_CDB_WIDTH,
   localparam int IW        = (NUM_FU > 1) ? $clog2(NUM_FU) : 1
)(
   input  logic                           clock,
   input  logic                           reset,
   input  FUNC_OUTPUT [NUM_FU-1:0]        fu_out,
   input  logic                           squash,
   output logic [NUM_FU-1:0]              fu_sel,
   output CDB_PACKET [CDB_WIDTH-1:0]      cdb,
   output logic [IW-1:0]                  rr_ptr
);

   logic [NUM_FU-1:0]                req;
   logic [NUM_FU-1:0]                gnt;
   logic [CDB_WIDTH-1:0]             slot_vld;
   logic [CDB_WIDTH-1:0][IW-1:0]     slot_idx;
   CDB_PACKET [CDB_WIDTH-1:0]        cdb_d;
   CDB_PACKET [CDB_WIDTH-1:0]        cdb_q;
   logic [IW-1:0]                    rr_d;
   logic [IW-1:0]                    rr_q;

   // Only the valid bits reach the picker: no data path into fu_sel.
   always_comb begin
      req = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         req[i] = fu_out[i].valid;
      end
   end

   rr_pick_n #(
      .N  (NUM_FU),
      .K  (CDB_WIDTH),
      .IW (IW)
   ) u_pick (
      .req_i      (req),
      .ptr_i      (rr_q),
      .gnt_o      (gnt),
      .slot_vld_o (slot_vld),
      .slot_idx_o (slot_idx)
   );

   assign fu_sel = (reset && !squash) ? gnt : '0;

   always_comb begin
      logic [IW-1:0] last;
      logic          hit;
      cdb_d = '0;
      rr_d  = rr_q;
      last  = '0;
      hit   = 1'b0;
      for (int s = 0; s < CDB_WIDTH; s++) begin
         if (slot_vld[s] && !squash) begin
            cdb_d[s] = fu_to_cdb(fu_out[slot_idx[s]]);
            last     = slot_idx[s];
            hit      = 1'b1;
         end
      end
      // Next search starts just past the last FU granted.
      if (hit) begin
         rr_d = (int'(last) == NUM_FU - 1) ? '0 : last + IW'(1);
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cdb_q <= '0;
         rr_q  <= '0;
      end else begin
         cdb_q <= cdb_d;
         rr_q  <= rr_d;
      end
   end

   assign cdb    = cdb_q;
   assign rr_ptr = rr_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Randomized self-checking bench for cdb_arbiter against a
// distance-ordered grant model, plus directed corner cases.
module tb_cdb_arbiter;
   import cdb_arbiter_pkg::*;

   localparam int N = 8;
   localparam int K = 2;

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic               squash = 1'b0;
   FUNC_OUTPUT [N-1:0] fu_out;
   logic [N-1:0]       fu_sel;
   CDB_PACKET [K-1:0]  cdb;
   logic [2:0]         rr_ptr;

   always #5 clock = ~clock;

   cdb_arbiter #(.NUM_FU(N), .CDB_WIDTH(K)) dut (
      .clock  (clock),
      .reset  (reset),
      .fu_out (fu_out),
      .squash (squash),
      .fu_sel (fu_sel),
      .cdb    (cdb),
      .rr_ptr (rr_ptr)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   FUNC_OUTPUT  res [N];
   bit          has [N];
   int          wait_c [N];
   bit          auto_gen = 1'b0;
   int          regap = 1;
   int          m_ptr = 0;
   logic [N-1:0] dut_sel;

   task automatic new_result(input int i);
      res[i].valid          = 1'b1;
      res[i].value          = $urandom;
      res[i].value_valid    = 1'($urandom_range(0, 1));
      res[i].dest_prf       = PRF_W'($urandom);
      res[i].rob_entry      = ROB_W'($urandom);
      res[i].branch_address = $urandom;
      has[i]                = 1'b1;
   endtask

   task automatic set_fu(input int i);
      new_result(i);
      res[i].rob_entry = ROB_W'(i + 16);
   endtask

   task automatic step(input bit sq);
      int          pick[$];
      bit          taken [N];
      logic [N-1:0] esel;
      CDB_PACKET   e;
      int          best;
      int          bd;
      int          d;
      for (int i = 0; i < N; i++) taken[i] = 1'b0;
      if (auto_gen) begin
         for (int i = 0; i < N; i++) begin
            if (!has[i]) begin
               if (wait_c[i] == 0) new_result(i);
               else wait_c[i]--;
            end
         end
      end
      for (int i = 0; i < N; i++) begin
         fu_out[i]       = res[i];
         fu_out[i].valid = has[i];
      end
      squash = sq;
      #1;
      esel = '0;
      if (!sq) begin
         for (int s = 0; s < K; s++) begin
            best = -1;
            bd   = N;
            for (int i = 0; i < N; i++) begin
               d = (i - m_ptr + N) % N;
               if (has[i] && !taken[i] && d < bd) begin
                  best = i;
                  bd   = d;
               end
            end
            if (best >= 0) begin
               taken[best] = 1'b1;
               esel[best]  = 1'b1;
               pick.push_back(best);
            end
         end
      end
      dut_sel = fu_sel;
      chk("fu_sel", fu_sel, esel);
      @(posedge clock);
      #1;
      for (int s = 0; s < K; s++) begin
         if (s < pick.size()) begin
            e                = '0;
            e.valid          = 1'b1;
            e.value          = res[pick[s]].value;
            e.value_valid    = res[pick[s]].value_valid;
            e.dest_prf       = res[pick[s]].dest_prf;
            e.rob_entry      = res[pick[s]].rob_entry;
            e.branch_address = res[pick[s]].branch_address;
            chk($sformatf("cdb%0d", s), cdb[s], e);
         end else begin
            chk($sformatf("cdb%0d_vld", s), cdb[s].valid, 1'b0);
         end
      end
      if (pick.size() > 0) m_ptr = (pick[pick.size() - 1] + 1) % N;
      chk("rr_ptr", rr_ptr, m_ptr);
      foreach (pick[p]) begin
         has[pick[p]]    = 1'b0;
         wait_c[pick[p]] = (regap < 0) ? $urandom_range(0, 3) : regap;
      end
      squash = 1'b0;
   endtask

   task automatic async_rst(input string tag);
      #2 reset = 1'b0;
      #1;
      for (int s = 0; s < K; s++) begin
         chk($sformatf("%s_cdb%0d", tag, s), cdb[s], '0);
      end
      chk({tag, "_ptr"}, rr_ptr, 0);
      chk({tag, "_sel"}, fu_sel, 0);
      @(negedge clock);
      reset = 1'b1;
      m_ptr = 0;
   endtask

   int prev [N];

   initial begin
      for (int i = 0; i < N; i++) begin
         new_result(i);
         fu_out[i] = res[i];
         wait_c[i] = 0;
         prev[i]   = -1;
      end
      #12;
      for (int s = 0; s < K; s++) begin
         chk($sformatf("rst_cdb%0d", s), cdb[s], '0);
      end
      chk("rst_ptr", rr_ptr, 0);
      chk("rst_sel", fu_sel, 0);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < N; i++) has[i] = 1'b0;

      set_fu(1); set_fu(3); set_fu(6);
      step(0);
      chk("r29_sel", dut_sel, 8'b0000_1010);
      chk("r29_ptr", rr_ptr, 4);
      @(negedge clock);
      step(0);
      chk("r29_fu6", cdb[0].rob_entry, 6 + 16);
      chk("r29_ptr2", rr_ptr, 7);
      @(negedge clock);

      set_fu(5);
      step(0);
      chk("r30_ptr6", rr_ptr, 6);
      @(negedge clock);
      set_fu(0); set_fu(7);
      step(0);
      chk("r30_sel", dut_sel, 8'b1000_0001);
      chk("r30_c0", cdb[0].rob_entry, 7 + 16);
      chk("r30_c1", cdb[1].rob_entry, 0 + 16);
      chk("r30_ptr", rr_ptr, 1);
      @(negedge clock);

      set_fu(2);
      res[2].dest_prf = 6'd12;
      res[2].value    = 32'hFFFF_FFFE;
      step(0);
      chk("r33_dest", cdb[0].dest_prf, 12);
      chk("r33_val", cdb[0].value, 32'hFFFF_FFFE);
      @(negedge clock);
      step(0);
      chk("r33_sel", dut_sel, 0);
      @(negedge clock);

      set_fu(4);
      step(0);
      chk("r32_c0", cdb[0].valid, 1);
      @(negedge clock);
      set_fu(0); set_fu(5); set_fu(6);
      step(1);
      chk("r32_sel", dut_sel, 0);
      chk("r32_ptr", rr_ptr, 5);
      @(negedge clock);
      step(0);
      chk("r32_resume", dut_sel, 8'b0110_0000);
      @(negedge clock);
      step(0);
      @(negedge clock);

      set_fu(1);
      step(0);
      chk("r28_pre", cdb[0].valid, 1);
      async_rst("r28");

      for (int i = 0; i < N; i++) new_result(i);
      auto_gen = 1'b1;
      regap    = 1;
      for (int c = 0; c < 20; c++) begin
         step(0);
         if (c >= 4) chk("r31_full", cdb[1].valid, 1);
         for (int i = 0; i < N; i++) begin
            if (dut_sel[i]) begin
               if (prev[i] >= 0) chk("r31_int", c - prev[i], 4);
               prev[i] = c;
            end
         end
         @(negedge clock);
      end

      regap = -1;
      for (int c = 0; c < 1500; c++) begin
         step($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 99) == 0) async_rst("rnd_rst");
         else @(negedge clock);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter NUM_FU, default 8, number of functional-unit result ports arbitrated.
REQ-002 Parameter CDB_WIDTH, default 2, number of result broadcasts per cycle (1..NUM_FU).
REQ-003 Port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port fu_out  input  FUNC_OUTPUT[NUM_FU]  per-FU result: valid, value, value_valid, dest_prf, rob_entry, branch_address.
REQ-006 Port squash  input  1  pipeline flush; discard all pending broadcasts.
REQ-007 Port fu_sel  output  NUM_FU  combinational one-cycle grant to each FU, which consumes its result at the next clock edge.
REQ-008 Port cdb  output  CDB_PACKET[CDB_WIDTH]  registered broadcast slots: valid, value, value_valid, dest_prf, rob_entry, branch_address.
REQ-009 Port rr_ptr  output  $clog2(NUM_FU)  current highest-priority FU index, for debug and coverage.

Function
REQ-010 Candidates are FUs with fu_out[i].valid high, searched circularly from rr_ptr upward with wrap from NUM_FU-1 to 0.
REQ-011 The first min(#candidates, CDB_WIDTH) candidates in search order are granted; fu_sel[i] is high only for those, never for an invalid FU.
REQ-012 fu_sel is a pure function of the current fu_out.valid, rr_ptr and squash, and carries no combinational path from fu_out data fields.
REQ-013 Grant k in search order loads cdb[k] at the next edge with valid=1 and fields copied unchanged from the granted FU.
REQ-014 cdb slots without a grant load valid=0; lower slots fill first, with no gaps.
REQ-015 Latency: FU result valid in cycle N with a grant -> on cdb during cycle N+1; each cdb entry is held one cycle only.
REQ-016 rr_ptr advances to (last granted index + 1) mod NUM_FU after any cycle with at least one grant; otherwise it holds.
REQ-017 Fairness: a continuously valid FU is granted within ceil(NUM_FU/CDB_WIDTH) cycles.
REQ-018 An FU is never granted in two consecutive cycles for the same result; this relies on the FU dropping valid the cycle after fu_sel.
REQ-019 squash high: fu_sel all zero, all cdb valid cleared at the next edge, rr_ptr holds.
REQ-020 Zero candidates: fu_sel all zero, all cdb valid 0 at the next edge.
REQ-021 Candidates exceeding CDB_WIDTH: unselected FUs keep valid and compete next cycle; no result is lost.

Reset
REQ-022 While reset is low (asynchronous assertion): cdb[*].valid=0, cdb data fields=0, rr_ptr=0.
REQ-023 fu_sel is 0 while reset is low.
REQ-024 Reset assertion mid-operation drops any in-flight broadcast; deassertion resumes with rr_ptr=0.

Structure
REQ-025 FUNC_OUTPUT, CDB_PACKET, and the NUM_FU/CDB_WIDTH defaults live in the shared pipeline package.
REQ-026 One sub-module, rr_pick_n: a combinational circular priority picker returning up to CDB_WIDTH one-hot grants plus their ordered indices.
REQ-027 All state (rr_ptr and the cdb registers) lives in the top-level cdb_arbiter.

Verification
REQ-028 Reset low mid-broadcast with cdb[0].valid=1 -> cdb[0].valid=0 and rr_ptr=0 immediately, before any clock edge.
REQ-029 NUM_FU=8, CDB_WIDTH=2, rr_ptr=0, FUs 1,3,6 valid -> fu_sel=8'b0000_1010, next cycle cdb[0]=FU1 and cdb[1]=FU3, rr_ptr=4; FU6 granted the following cycle in cdb[0], rr_ptr=7.
REQ-030 rr_ptr=6, FUs 0,7 valid -> grant order 7 then 0 (wrap), cdb[0]=FU7, cdb[1]=FU0, rr_ptr=1.
REQ-031 All 8 FUs valid, each re-raising valid 2 cycles after its grant -> every FU granted exactly once per 4 cycles, no cdb gaps.
REQ-032 squash asserted with 3 valid FUs and cdb[0].valid=1 -> fu_sel=0, cdb all invalid next cycle, rr_ptr unchanged, FUs still valid afterwards.
REQ-033 Mult FU raising out.valid with dest_prf=12, value=32'hFFFF_FFFE -> cdb[0] carries dest_prf=12 and the same value one cycle later; FU valid low the cycle after sel.
